// File: rtl/skew_sync_pkg.sv
// Shared types and constants for the multi_skewed_sync block.
//   skew_mode_t : SYNC maximises 1-overlap with the reference channel,
//                 DESYNC minimises it.
//   DEP_MAX     : largest supported per-lane counter width.
package skew_sync_pkg;

   typedef enum logic {
      SYNC   = 1'b0,
      DESYNC = 1'b1
   } skew_mode_t;

   localparam int unsigned DEP_MAX = 8;

endpackage

// File: rtl/skew_sync_lane.sv
// One non-reference lane of multi_skewed_sync: a DEP-bit saturating
// store counter plus the decision logic that delays or releases 1s to
// line them up with (SYNC) or away from (DESYNC) the reference stream.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the counter
//   en_i    : stream advance; low holds the counter and passes in_i through
//   flush_i : drain stored 1s regardless of the reference
//   in_i    : lane input bit
//   ref_i   : reference channel bit
//   out_o   : adjusted lane bit (combinational)
//   sat_o   : store request hit a full counter (combinational)
module skew_sync_lane
   import skew_sync_pkg::*;
#(
   parameter int unsigned DEP  = 2,
   parameter skew_mode_t  MODE = SYNC
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic flush_i,
   input  logic in_i,
   input  logic ref_i,
   output logic out_o,
   output logic sat_o
);

   logic [DEP-1:0] cnt_q;
   logic [DEP-1:0] cnt_d;
   logic           full;
   logic           empty;
   logic           store;
   logic           drain;

   assign full  = &cnt_q;
   assign empty = (cnt_q == '0);

   // store: a lane 1 that should be held back; drain: a slot where a held 1
   // can be emitted. The two modes differ only in the reference polarity.
   assign store = (MODE == SYNC) ? ( in_i & ~ref_i) : ( in_i &  ref_i);
   assign drain = (MODE == SYNC) ? (~in_i &  ref_i) : (~in_i & ~ref_i);

   always_comb begin
      cnt_d = cnt_q;
      out_o = in_i;
      sat_o = 1'b0;
      if (en_i) begin
         if (flush_i) begin
            if (in_i) begin
               out_o = 1'b1;
            end else if (!empty) begin
               out_o = 1'b1;
               cnt_d = cnt_q - DEP'(1);
            end else begin
               out_o = 1'b0;
            end
         end else if (store) begin
            if (!full) begin
               out_o = 1'b0;
               cnt_d = cnt_q + DEP'(1);
            end else begin
               out_o = 1'b1;
               sat_o = 1'b1;
            end
         end else if (drain) begin
            if (!empty) begin
               out_o = 1'b1;
               cnt_d = cnt_q - DEP'(1);
            end else begin
               out_o = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multi_skewed_sync.sv
// Multi-channel stochastic bitstream skew adjuster. Channel 0 is the
// reference and passes through; channels 1..CH-1 each get a
// skew_sync_lane that correlates (SYNC) or decorrelates (DESYNC) them
// with the reference.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   en      : stream advance; low = stall
//   flush   : drain stored 1s regardless of the reference
//   in      : CH input bitstreams, bit 0 = reference
//   out     : CH adjusted bitstreams
//   out_vld : out holds a valid stream bit (mirrors en)
//   sat     : per-lane saturation pulse, bit 0 always 0
// Build option: define MULTI_SKEWED_SYNC_OUT_REG_EN to register out, sat
// and out_vld (1-cycle latency); otherwise they are combinational.
module multi_skewed_sync
   import skew_sync_pkg::*;
#(
   parameter int unsigned CH   = 3,
   parameter int unsigned DEP  = 2,
   parameter skew_mode_t  MODE = SYNC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          flush,
   input  logic [CH-1:0] in,
   output logic [CH-1:0] out,
   output logic          out_vld,
   output logic [CH-1:0] sat
);

   logic [CH-1:0] out_d;
   logic [CH-1:0] sat_d;
   logic          vld_d;

   assign out_d[0] = in[0];
   assign sat_d[0] = 1'b0;
   assign vld_d    = en;

   for (genvar i = 1; i < CH; i++) begin : g_lane
      skew_sync_lane #(
         .DEP  (DEP),
         .MODE (MODE)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .en_i    (en),
         .flush_i (flush),
         .in_i    (in[i]),
         .ref_i   (in[0]),
         .out_o   (out_d[i]),
         .sat_o   (sat_d[i])
      );
   end

`ifdef MULTI_SKEWED_SYNC_OUT_REG_EN
   logic [CH-1:0] out_q;
   logic [CH-1:0] sat_q;
   logic          vld_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         sat_q <= '0;
         vld_q <= 1'b0;
      end else begin
         out_q <= out_d;
         sat_q <= sat_d;
         vld_q <= vld_d;
      end
   end

   assign out     = out_q;
   assign sat     = sat_q;
   assign out_vld = vld_q;
`else
   assign out     = out_d;
   assign sat     = sat_d;
   assign out_vld = vld_d;
`endif

endmodule

// File: tb/tb_multi_skewed_sync.sv
// Directed self-checking bench for multi_skewed_sync (CH=3, DEP=2,
// combinational output build). One SYNC and one DESYNC instance share
// clock, reset, en and flush; each has its own input vector.
module tb_multi_skewed_sync;
   import skew_sync_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       flush = 1'b0;
   logic [2:0] in_s = '0;
   logic [2:0] in_d = '0;
   logic [2:0] out_s, out_d, sat_s, sat_d;
   logic       vld_s, vld_d;
   logic [1:0] c1_s, c2_s, c1_d;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   multi_skewed_sync #(.CH(3), .DEP(2), .MODE(SYNC)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .in(in_s),
      .out(out_s), .out_vld(vld_s), .sat(sat_s)
   );

   multi_skewed_sync #(.CH(3), .DEP(2), .MODE(DESYNC)) dut_d (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .in(in_d),
      .out(out_d), .out_vld(vld_d), .sat(sat_d)
   );

   assign c1_s = dut.g_lane[1].u_lane.cnt_q;
   assign c2_s = dut.g_lane[2].u_lane.cnt_q;
   assign c1_d = dut_d.g_lane[1].u_lane.cnt_q;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Drive inputs just after a rising edge and wait for the falling edge,
   // where the combinational outputs are stable.
   task automatic drive(input logic e, input logic f, input logic [2:0] vs, input logic [2:0] vd);
      en    = e;
      flush = f;
      in_s  = vs;
      in_d  = vd;
      @(negedge clk);
   endtask

   // Let the counters take the next rising edge.
   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_c1", 32'(c1_s), 32'd0);
      check("rst_c2", 32'(c2_s), 32'd0);
      check("rst_out", 32'(out_s), 32'd0);
      check("rst_vld", 32'(vld_s), 32'd0);
      rst = 1'b0;
      #1;

      // Reset release: ref=1, in1=1 passes, lane 2 has nothing to drain
      drive(1'b1, 1'b0, 3'b011, 3'b000);
      check("rel_out", 32'(out_s), 32'b011);
      check("rel_sat", 32'(sat_s), 32'd0);
      check("rel_vld", 32'(vld_s), 32'd1);
      settle();
      check("rel_c2", 32'(c2_s), 32'd0);
      check("rel_c1", 32'(c1_s), 32'd0);

      // SYNC store until saturation: ref=0, in1=1
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 3'b010, 3'b000);
         check("sat_out", 32'(out_s), (k == 3) ? 32'b010 : 32'b000);
         check("sat_sat", 32'(sat_s), (k == 3) ? 32'b010 : 32'b000);
         settle();
         check("sat_c1", 32'(c1_s), (k < 3) ? 32'(k + 1) : 32'd3);
      end

      // SYNC drain: ref=1, in1=0
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 3'b001, 3'b000);
         check("drn_out", 32'(out_s), (k < 3) ? 32'b011 : 32'b001);
         check("drn_sat", 32'(sat_s), 32'd0);
         settle();
         check("drn_c1", 32'(c1_s), (k < 3) ? 32'(2 - k) : 32'd0);
      end

      // Flush: load cnt1=2, then flush with in1=0
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 3'b010, 3'b000);
         settle();
      end
      check("fl_pre_c1", 32'(c1_s), 32'd2);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 3'b000, 3'b000);
         check("fl_out", 32'(out_s), (k < 2) ? 32'b010 : 32'b000);
         settle();
         check("fl_c1", 32'(c1_s), (k < 2) ? 32'(1 - k) : 32'd0);
      end
      // Flush with in1=1 and ref=0 passes the 1 and holds the empty counter
      drive(1'b1, 1'b1, 3'b010, 3'b000);
      check("fl1_out", 32'(out_s), 32'b010);
      check("fl1_sat", 32'(sat_s), 32'd0);
      settle();
      check("fl1_c1", 32'(c1_s), 32'd0);

      // Stall: fill cnt1=3, then en=0 for 5 cycles
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 3'b010, 3'b000);
         settle();
      end
      check("st_pre_c1", 32'(c1_s), 32'd3);
      begin
         logic [2:0] sv [5];
         sv = '{3'b010, 3'b001, 3'b111, 3'b100, 3'b011};
         for (int k = 0; k < 5; k++) begin
            drive(1'b0, (k == 1 || k == 3), sv[k], 3'b000);
            check("st_out", 32'(out_s), 32'(sv[k]));
            check("st_sat", 32'(sat_s), 32'd0);
            check("st_vld", 32'(vld_s), 32'd0);
            settle();
            check("st_c1", 32'(c1_s), 32'd3);
         end
      end

      // Asynchronous reset mid-cycle discards stored 1s at once
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("ar_c1", 32'(c1_s), 32'd0);
      settle();
      rst = 1'b0;
      drive(1'b1, 1'b0, 3'b011, 3'b000);
      check("ar_rel_out", 32'(out_s), 32'b011);
      settle();
      check("ar_rel_c1", 32'(c1_s), 32'd0);

      // DESYNC: ref=1,in1=1 stores; then ref=0,in1=0 releases
      drive(1'b1, 1'b0, 3'b000, 3'b011);
      check("ds_out0", 32'(out_d), 32'b001);
      settle();
      check("ds_c1a", 32'(c1_d), 32'd1);
      drive(1'b1, 1'b0, 3'b000, 3'b000);
      check("ds_out1", 32'(out_d), 32'b010);
      check("ds_sat", 32'(sat_d), 32'd0);
      settle();
      check("ds_c1b", 32'(c1_d), 32'd0);

      // DESYNC saturation: ref=1,in1=1 four times
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 3'b000, 3'b011);
         check("dsat_out", 32'(out_d), (k == 3) ? 32'b011 : 32'b001);
         check("dsat_sat", 32'(sat_d), (k == 3) ? 32'b010 : 32'b000);
         settle();
         check("dsat_c1", 32'(c1_d), (k < 3) ? 32'(k + 1) : 32'd3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
